// File: rtl/result_image_data_storage.sv
// rtl/result_image_data_storage.sv - packs edge-detected pixels into padded 32-bit words and writes them to SRAM (optional EDGE_THRESHOLD_EN binarises pixels)
module result_image_data_storage #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 20,
  parameter int THRESHOLD  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       image_width,
  input  logic [31:0]       image_height,
  input  logic              start,
  input  logic              ED_wvalid,
  input  logic [7:0]        ED_wdata,
  output logic              ED_wready,
  output logic [1:0]        SO_mode,
  output logic [ADDR_W-1:0] SO_wpixNum,
  output logic [31:0]       SO_wdata,
  input  logic              SO_dfw,
  output logic              busy,
  output logic              frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [8:0] THR9 = 9'(THRESHOLD);

`ifdef EDGE_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  typedef enum logic {W_IDLE, W_REQ} wstate_t;

  wstate_t w_state, w_next;

  // frame geometry latched at start
  logic [ADDR_W-1:0] out_w_m1;
  logic [ADDR_W-1:0] out_h;
  logic [ADDR_W-1:0] stride;

  // pixel position and packing
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic [31:0]       pack;
  logic [31:0]       pack_ins;

  // word FIFO between packer and writer
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pixels_left;
  logic              accept;
  logic              row_end;
  logic              push;
  logic              push_last;
  logic [ADDR_W-1:0] push_addr;
  logic [7:0]        pix_byte;
  logic              load;
  logic              pop;
  logic              too_small;
  logic [ADDR_W-1:0] w_in;
  logic [ADDR_W-1:0] h_in;

  assign w_in      = image_width[ADDR_W-1:0] - ADDR_W'(2);
  assign h_in      = image_height[ADDR_W-1:0] - ADDR_W'(2);
  assign too_small = (image_width < 32'd3) || (image_height < 32'd3);

  assign fifo_full   = (fifo_cnt == DEPTH_C);
  assign fifo_empty  = (fifo_cnt == '0);
  // row reaches out_h only once every pixel of the frame has been taken
  assign pixels_left = (row != out_h);
  assign ED_wready   = busy && !fifo_full && pixels_left;
  assign accept      = ED_wvalid && ED_wready;

  assign pix_byte  = THR_EN ? (({1'b0, ED_wdata} >= THR9) ? 8'hFF : 8'h00) : ED_wdata;
  assign row_end   = (col == out_w_m1);
  assign push      = accept && ((col[1:0] == 2'b11) || row_end);
  assign push_last = row_end && ((row + ADDR_W'(1)) == out_h);
  assign push_addr = row_base + {col[ADDR_W-1:2], 2'b00};

  assign SO_mode = (w_state == W_REQ) ? 2'b10 : 2'b00;

  // insert the incoming byte into its lane; lanes not yet written stay zero
  always_comb begin
    pack_ins = pack;
    case (col[1:0])
      2'b00:   pack_ins[7:0]   = pix_byte;
      2'b01:   pack_ins[15:8]  = pix_byte;
      2'b10:   pack_ins[23:16] = pix_byte;
      default: pack_ins[31:24] = pix_byte;
    endcase
  end

  // frame control: geometry latch, row/col walk, pack register, busy/frame_done
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      out_w_m1   <= '0;
      out_h      <= '0;
      stride     <= '0;
      row        <= '0;
      col        <= '0;
      row_base   <= '0;
      pack       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (start && !busy) begin
        if (too_small) begin
          frame_done <= 1'b1;
        end else begin
          busy     <= 1'b1;
          out_w_m1 <= w_in - ADDR_W'(1);
          out_h    <= h_in;
          stride   <= (w_in + ADDR_W'(3)) & ~ADDR_W'(3);
          row      <= '0;
          col      <= '0;
          row_base <= '0;
          pack     <= '0;
        end
      end else if (busy) begin
        if (accept) begin
          pack <= push ? 32'h0 : pack_ins;
          if (row_end) begin
            col      <= '0;
            row      <= row + ADDR_W'(1);
            row_base <= row_base + stride;
          end else begin
            col <= col + ADDR_W'(1);
          end
        end
        if (pop && fifo_last[rd_ptr]) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= pack_ins;
      fifo_addr[wr_ptr] <= push_addr;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  // writer state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // writer next state: load head when idle, pop on write-done
  always_comb begin
    w_next = w_state;
    load   = 1'b0;
    pop    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (!fifo_empty) begin
          load   = 1'b1;
          w_next = W_REQ;
        end
      end
      W_REQ: begin
        if (SO_dfw) begin
          pop    = 1'b1;
          w_next = W_IDLE;
        end
      end
    endcase
  end

  // request word/address registers, held stable for the whole request
  always_ff @(posedge clk) begin
    if (rst) begin
      SO_wdata   <= 32'h0;
      SO_wpixNum <= '0;
    end else if (load) begin
      SO_wdata   <= fifo_data[rd_ptr];
      SO_wpixNum <= fifo_addr[rd_ptr];
    end
  end

endmodule

// File: tb/tb_result_image_data_storage.sv
// tb/tb_result_image_data_storage.sv - scoreboard bench for result_image_data_storage
`timescale 1ns/1ps
module tb_result_image_data_storage;

  localparam int ADDR_W = 20;

  logic              tb_clk = 1'b0;
  logic              rst;
  logic [31:0]       image_width;
  logic [31:0]       image_height;
  logic              start;
  logic              ED_wvalid;
  logic [7:0]        ED_wdata;
  logic              ED_wready;
  logic [1:0]        SO_mode;
  logic [ADDR_W-1:0] SO_wpixNum;
  logic [31:0]       SO_wdata;
  logic              SO_dfw;
  logic              busy;
  logic              frame_done;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  cur_req;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   dfw_delay = 2;
  int   wait_cnt = 0;
  logic [1:0] prev_mode = 2'b00;
  int   hs_count = 0;
  int   first_hs_cyc = -1;
  int   last_hs_cyc = -1;
  int   accepted = 0;
  int   stall_acc = -1;
  int   resume_cyc = -2;
  bit   stalled = 0;
  bit   resumed = 0;

  result_image_data_storage #(
    .FIFO_DEPTH(2),
    .ADDR_W(ADDR_W),
    .THRESHOLD(128)
  ) dut (
    .clk(tb_clk),
    .rst(rst),
    .image_width(image_width),
    .image_height(image_height),
    .start(start),
    .ED_wvalid(ED_wvalid),
    .ED_wdata(ED_wdata),
    .ED_wready(ED_wready),
    .SO_mode(SO_mode),
    .SO_wpixNum(SO_wpixNum),
    .SO_wdata(SO_wdata),
    .SO_dfw(SO_dfw),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // SRAM responder followed by the scoreboard monitor, both on the falling edge
  initial begin
    SO_dfw = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (SO_dfw) begin
        SO_dfw   = 1'b0;
        wait_cnt = 0;
      end else if (SO_mode == 2'b10) begin
        if (wait_cnt >= dfw_delay) SO_dfw = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end

      if (SO_mode == 2'b10 && prev_mode != 2'b10) begin
        cur_req.addr = SO_wpixNum;
        cur_req.data = SO_wdata;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", SO_wpixNum, SO_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", SO_wpixNum, e.addr);
          check("write_data", SO_wdata, e.data);
        end
      end
      if (SO_mode == 2'b10 && SO_dfw) begin
        check("hold_addr", SO_wpixNum, cur_req.addr);
        check("hold_data", SO_wdata, cur_req.data);
        last_hs_cyc = cyc + 1;
        if (hs_count == 0) first_hs_cyc = cyc + 1;
        hs_count++;
      end
      prev_mode = SO_mode;
    end
  end

  task automatic start_frame(input int w, input int h);
    image_width  = w;
    image_height = h;
    start        = 1'b1;
    @(negedge tb_clk);
    start        = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] d);
    int t;
    t = 0;
    ED_wvalid = 1'b1;
    ED_wdata  = d;
    while (!ED_wready && t < 200) begin
      if (!stalled) begin
        stalled   = 1;
        stall_acc = accepted;
      end
      @(negedge tb_clk);
      t++;
    end
    if (!ED_wready) begin
      total++;
      bad++;
      $display("FAIL pixel_accept: ready stayed 0 for %0d cycles, required 1", t);
    end else begin
      if (stalled && !resumed) begin
        resumed    = 1;
        resume_cyc = cyc;
      end
      accepted++;
      @(negedge tb_clk);
    end
  endtask

  task automatic wait_done(input string name, input bit expect_hs);
    int t;
    t = 0;
    while (!frame_done && t < 500) begin
      @(negedge tb_clk);
      t++;
    end
    check({name, "_frame_done"}, frame_done, 1);
    if (frame_done) begin
      if (expect_hs) check({name, "_done_after_dfw"}, cyc, last_hs_cyc);
      @(negedge tb_clk);
      check({name, "_done_pulse"}, frame_done, 0);
      check({name, "_busy_idle"}, busy, 0);
      check({name, "_queue_empty"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    image_width = 0;
    image_height = 0;
    ED_wvalid = 1'b0;
    ED_wdata = 8'h00;
    repeat (2) @(negedge tb_clk);
    check("rst_mode", SO_mode, 2'b00);
    check("rst_addr", SO_wpixNum, 0);
    check("rst_data", SO_wdata, 0);
    check("rst_ready", ED_wready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;
    @(negedge tb_clk);

    // reset while a request is outstanding and the FIFO is full
    dfw_delay = 1000;
    exp_wr(0, 32'h04030201);
    exp_wr(4, 32'h08070605);
    start_frame(18, 3);
    for (int i = 1; i <= 8; i++) send_px(8'(i));
    ED_wvalid = 1'b0;
    check("pre_rst_mode", SO_mode, 2'b10);
    check("pre_rst_full", ED_wready, 0);
    rst = 1'b1;
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    exp_q.delete();
    dfw_delay = 2;
    check("mid_rst_mode", SO_mode, 2'b00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ED_wready, 0);
    check("mid_rst_data", SO_wdata, 0);
    check("mid_rst_addr", SO_wpixNum, 0);
    @(negedge tb_clk);

    // 4x1 output, single word
    dfw_delay = 2;
    exp_wr(0, 32'h44332211);
    start_frame(6, 3);
    check("t4x1_busy", busy, 1);
    send_px(8'h11); send_px(8'h22); send_px(8'h33); send_px(8'h44);
    ED_wvalid = 1'b0;
    wait_done("t4x1", 1);

    // 5x2 output, stride 8, row padding
    dfw_delay = 0;
    exp_wr(0,  32'h04030201);
    exp_wr(4,  32'h00000005);
    exp_wr(8,  32'h09080706);
    exp_wr(12, 32'h0000000A);
    start_frame(7, 4);
    for (int i = 1; i <= 10; i++) send_px(8'(i));
    ED_wvalid = 1'b0;
    wait_done("t5x2", 1);

    // backpressure: write-done withheld
    dfw_delay = 20;
    stalled = 0; resumed = 0; accepted = 0; hs_count = 0;
    exp_wr(0,  32'h04030201);
    exp_wr(4,  32'h08070605);
    exp_wr(8,  32'h0C0B0A09);
    exp_wr(12, 32'h100F0E0D);
    start_frame(18, 3);
    for (int i = 1; i <= 16; i++) send_px(8'(i));
    ED_wvalid = 1'b0;
    check("bp_all_taken_ready", ED_wready, 0);
    wait_done("bp", 1);
    check("bp_stall_count", stall_acc, 8);
    check("bp_resumed", resumed, 1);
    check("bp_resume_cycle", resume_cyc, first_hs_cyc);

    // threshold option
    dfw_delay = 1;
`ifdef EDGE_THRESHOLD_EN
    exp_wr(0, 32'hFF00FF00);
`else
    exp_wr(0, 32'hFF00807F);
`endif
    start_frame(6, 3);
    send_px(8'h7F); send_px(8'h80); send_px(8'h00); send_px(8'hFF);
    ED_wvalid = 1'b0;
    wait_done("thr", 1);

    // degenerate sizes
    ED_wvalid = 1'b1;
    ED_wdata  = 8'h55;
    start_frame(2, 10);
    check("tiny_w_done", frame_done, 1);
    check("tiny_w_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge tb_clk);
      check("tiny_w_mode", SO_mode, 2'b00);
      check("tiny_w_ready", ED_wready, 0);
      check("tiny_w_pulse", frame_done, 0);
    end
    start_frame(10, 2);
    check("tiny_h_done", frame_done, 1);
    check("tiny_h_busy", busy, 0);
    @(negedge tb_clk);
    check("tiny_h_ready", ED_wready, 0);
    ED_wvalid = 1'b0;
    repeat (3) @(negedge tb_clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
